// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// opcodes, ALU operations and the datapath mux-select codes.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXEC_R   = 4'd6,
      EXEC_I   = 4'd7,
      ALUWB    = 4'd8,
      BEQ_CMP  = 4'd9,
      BEQ_TGT  = 4'd10,
      JAL_LINK = 4'd11,
      JAL_TGT  = 4'd12
   } state_t;

   // How the ALU op is chosen: fixed ADD, fixed SUB, or from funct3/funct7
   typedef enum logic [1:0] {
      MODE_ADD   = 2'd0,
      MODE_SUB   = 2'd1,
      MODE_FUNCT = 2'd2
   } alu_mode_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [1:0] RES_ALU_OUT    = 2'b00;
   localparam logic [1:0] RES_READ_DATA  = 2'b01;
   localparam logic [1:0] RES_ALU_RESULT = 2'b10;

   localparam logic [1:0] SRCA_PC  = 2'b00;
   localparam logic [1:0] SRCA_RS1 = 2'b01;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_ZERO = 2'b11;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-op decoder. funct7[5] selects SUB only for R-type
// ADD/SUB; for shifts-right it picks SRA in both R- and I-type forms.
module alu_decoder
   import ctrl_pkg::*;
(
   input  alu_mode_t  alu_mode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output logic [3:0] alu_control
);

   // Map mode + instruction fields onto an ALU operation
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_mode)
         MODE_SUB: alu_control = ALU_SUB;
         MODE_FUNCT: begin
            case (funct3)
               3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: sequences each instruction through its
// states and drives the shared-memory datapath's enables and selects.
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             zero,
   output logic             pc_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             mem_write,
   output logic             instruction_or_data,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_control,
   output logic [1:0]       imm_src,
   output logic             retire,
   output logic             illegal_instr,
   output logic [3:0]       state_dbg,
   output logic [CNT_W-1:0] instret
);

   state_t           state_reg, state_next;
   logic             br_taken_reg;
   logic [CNT_W-1:0] instret_reg;
   alu_mode_t        alu_mode;
   logic             pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw;
   logic             retire_raw, illegal_raw;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       unused_instr_bits;

   assign opcode            = instr[6:0];
   assign funct3            = instr[14:12];
   assign funct7_5          = instr[30];
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   alu_decoder u_alu_decoder (
      .alu_mode    (alu_mode),
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .is_rtype    (opcode == OP_RTYPE),
      .alu_control (alu_control)
   );

   // State register; reset abandons any partial instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= FETCH;
      else       state_reg <= state_next;
   end

   // Branch decision is captured in BEQ_CMP and consumed in BEQ_TGT
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                     br_taken_reg <= 1'b0;
      else if (state_reg == BEQ_CMP) br_taken_reg <= zero;
   end

   // Retired-instruction counter, wraps silently
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           instret_reg <= '0;
      else if (retire_raw) instret_reg <= instret_reg + CNT_W'(1);
   end

   // Next-state and Moore output decode
   always_comb begin
      state_next          = FETCH;
      pc_write_raw        = 1'b0;
      ir_write_raw        = 1'b0;
      reg_write_raw       = 1'b0;
      mem_write_raw       = 1'b0;
      retire_raw          = 1'b0;
      illegal_raw         = 1'b0;
      instruction_or_data = 1'b0;
      result_src          = RES_ALU_OUT;
      alu_src_a           = SRCA_PC;
      alu_src_b           = SRCB_RS2;
      imm_src             = IMM_I;
      alu_mode            = MODE_ADD;
      case (state_reg)
         FETCH: begin
            ir_write_raw = 1'b1;
            pc_write_raw = 1'b1;
            alu_src_b    = SRCB_FOUR;
            state_next   = DECODE;
         end
         DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_next = MEMADR;
               OP_RTYPE:          state_next = EXEC_R;
               OP_ITYPE:          state_next = EXEC_I;
               OP_BRANCH:         state_next = BEQ_CMP;
               OP_JAL:            state_next = JAL_LINK;
               default:           illegal_raw = 1'b1;
            endcase
         end
         MEMADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
            state_next = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            instruction_or_data = 1'b1;
            state_next          = MEMWB;
         end
         MEMWB: begin
            result_src    = RES_READ_DATA;
            reg_write_raw = 1'b1;
            retire_raw    = 1'b1;
         end
         MEMWRITE: begin
            mem_write_raw = 1'b1;
            retire_raw    = 1'b1;
         end
         EXEC_R: begin
            alu_src_a  = SRCA_RS1;
            alu_mode   = MODE_FUNCT;
            state_next = ALUWB;
         end
         EXEC_I: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_mode   = MODE_FUNCT;
            state_next = ALUWB;
         end
         ALUWB: begin
            reg_write_raw = 1'b1;
            retire_raw    = 1'b1;
         end
         BEQ_CMP: begin
            alu_src_a  = SRCA_RS1;
            alu_mode   = MODE_SUB;
            state_next = BEQ_TGT;
         end
         BEQ_TGT: begin
            alu_src_b    = SRCB_IMM;
            imm_src      = IMM_B;
            pc_write_raw = br_taken_reg;
            retire_raw   = 1'b1;
         end
         JAL_LINK: begin
            alu_src_b     = SRCB_ZERO;
            result_src    = RES_ALU_RESULT;
            reg_write_raw = 1'b1;
            state_next    = JAL_TGT;
         end
         JAL_TGT: begin
            alu_src_b    = SRCB_IMM;
            imm_src      = IMM_J;
            pc_write_raw = 1'b1;
            retire_raw   = 1'b1;
         end
         default: state_next = FETCH;
      endcase
   end

   // Side-effecting outputs are held off for as long as reset is high
   assign pc_write      = pc_write_raw  & ~reset;
   assign ir_write      = ir_write_raw  & ~reset;
   assign reg_write     = reg_write_raw & ~reset;
   assign mem_write     = mem_write_raw & ~reset;
   assign retire        = retire_raw    & ~reset;
   assign illegal_instr = illegal_raw   & ~reset;
   assign state_dbg     = state_reg;
   assign instret       = instret_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table-driven bench for the multicycle control unit: one row per clock
// cycle, plus hand sequences for mid-instruction reset and counter wrap.
module tb_multicycle_control_fsm;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [31:0]      instr = 32'h0;
   logic             zero = 1'b0;
   logic             pc_write, ir_write, reg_write, mem_write, instruction_or_data;
   logic [1:0]       result_src, alu_src_a, alu_src_b, imm_src;
   logic [3:0]       alu_control, state_dbg;
   logic             retire, illegal_instr;
   logic [CNT_W-1:0] instret;

   multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
      .clk                 (clk),
      .reset               (reset),
      .instr               (instr),
      .zero                (zero),
      .pc_write            (pc_write),
      .ir_write            (ir_write),
      .reg_write           (reg_write),
      .mem_write           (mem_write),
      .instruction_or_data (instruction_or_data),
      .result_src          (result_src),
      .alu_src_a           (alu_src_a),
      .alu_src_b           (alu_src_b),
      .alu_control         (alu_control),
      .imm_src             (imm_src),
      .retire              (retire),
      .illegal_instr       (illegal_instr),
      .state_dbg           (state_dbg),
      .instret             (instret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, rw, mw, iod;
      logic [1:0] rs, a, b;
      logic [3:0] alu;
      logic [1:0] imm;
      logic       ret, ill;
   } outs_t;

   typedef struct {
      logic        rst;
      logic [31:0] ins;
      logic        z;
      outs_t       exp;
      string       name;
   } vec_t;

   int         n_vec = 0;
   int         n_bad = 0;
   logic [3:0] exp_cnt = 4'd0;
   vec_t       tbl[$];

   function automatic outs_t mk(input logic [3:0] st, input logic pcw, irw, rw, mw, iod,
                                input logic [1:0] rs, a, b, input logic [3:0] alu,
                                input logic [1:0] imm, input logic ret, ill);
      return {st, pcw, irw, rw, mw, iod, rs, a, b, alu, imm, ret, ill};
   endfunction

   function automatic outs_t actual();
      return {state_dbg, pc_write, ir_write, reg_write, mem_write, instruction_or_data,
              result_src, alu_src_a, alu_src_b, alu_control, imm_src, retire, illegal_instr};
   endfunction

   task automatic add(input logic rst, input logic [31:0] ins, input logic z,
                      input outs_t exp, input string name);
      vec_t v;
      v.rst = rst; v.ins = ins; v.z = z; v.exp = exp; v.name = name;
      tbl.push_back(v);
   endtask

   // Drive one cycle's inputs, compare outputs and counter, track retires
   task automatic check_row(input logic rst, input logic [31:0] ins, input logic z,
                            input outs_t exp, input string name);
      outs_t act;
      @(negedge clk);
      reset = rst; instr = ins; zero = z;
      #1;
      if (rst) exp_cnt = 4'd0;
      act = actual();
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: outputs got %h want %h", name, act, exp);
      end
      n_vec++;
      if (instret !== exp_cnt) begin
         n_bad++;
         $display("FAIL %s instret: got %0d want %0d", name, instret, exp_cnt);
      end
      $display("vec %-10s instr=%h st=%0d out=%h instret=%0d", name, ins, state_dbg, act, instret);
      if (!rst && exp.ret) exp_cnt = exp_cnt + 4'd1;
   endtask

   outs_t R_ST, F_ST, D_ST, W_ST, EI_ADD;

   initial begin
      R_ST   = mk(4'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 4'd0, 2'd0, 0, 0);
      F_ST   = mk(4'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd1, 4'd0, 2'd0, 0, 0);
      D_ST   = mk(4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 2'd0, 0, 0);
      W_ST   = mk(4'd8, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 2'd0, 1, 0);
      EI_ADD = mk(4'd7, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 4'd0, 2'd0, 0, 0);

      // reset, then addi x1,x0,10
      add(1, 32'h0, 0, R_ST, "reset");
      add(0, 32'h00A00093, 0, F_ST, "addi_f");
      add(0, 32'h00A00093, 0, D_ST, "addi_d");
      add(0, 32'h00A00093, 0, EI_ADD, "addi_ex");
      add(0, 32'h00A00093, 0, W_ST, "addi_wb");
      // sub x0,x1,x2
      add(0, 32'h40208033, 0, F_ST, "sub_f");
      add(0, 32'h40208033, 0, D_ST, "sub_d");
      add(0, 32'h40208033, 0, mk(4'd6, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 4'd1, 2'd0, 0, 0), "sub_ex");
      add(0, 32'h40208033, 0, W_ST, "sub_wb");
      // lw
      add(0, 32'h0000A103, 0, F_ST, "lw_f");
      add(0, 32'h0000A103, 0, D_ST, "lw_d");
      add(0, 32'h0000A103, 0, mk(4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 4'd0, 2'd0, 0, 0), "lw_adr");
      add(0, 32'h0000A103, 0, mk(4'd3, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 2'd0, 0, 0), "lw_rd");
      add(0, 32'h0000A103, 0, mk(4'd4, 0, 0, 1, 0, 0, 2'd1, 2'd0, 2'd0, 4'd0, 2'd0, 1, 0), "lw_wb");
      // sw
      add(0, 32'h0020A023, 0, F_ST, "sw_f");
      add(0, 32'h0020A023, 0, D_ST, "sw_d");
      add(0, 32'h0020A023, 0, mk(4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 4'd0, 2'd1, 0, 0), "sw_adr");
      add(0, 32'h0020A023, 0, mk(4'd5, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 4'd0, 2'd0, 1, 0), "sw_wr");
      // beq taken: zero high only during compare, branch must still be taken
      add(0, 32'h00208463, 0, F_ST, "beqt_f");
      add(0, 32'h00208463, 0, D_ST, "beqt_d");
      add(0, 32'h00208463, 1, mk(4'd9, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 4'd1, 2'd0, 0, 0), "beqt_cmp");
      add(0, 32'h00208463, 0, mk(4'd10, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 4'd0, 2'd2, 1, 0), "beqt_tgt");
      // beq not taken: zero high only during target, branch must not be taken
      add(0, 32'h00208463, 0, F_ST, "beqn_f");
      add(0, 32'h00208463, 0, D_ST, "beqn_d");
      add(0, 32'h00208463, 0, mk(4'd9, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 4'd1, 2'd0, 0, 0), "beqn_cmp");
      add(0, 32'h00208463, 1, mk(4'd10, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 4'd0, 2'd2, 1, 0), "beqn_tgt");
      // jal
      add(0, 32'h008000EF, 0, F_ST, "jal_f");
      add(0, 32'h008000EF, 0, D_ST, "jal_d");
      add(0, 32'h008000EF, 0, mk(4'd11, 0, 0, 1, 0, 0, 2'd2, 2'd0, 2'd3, 4'd0, 2'd0, 0, 0), "jal_link");
      add(0, 32'h008000EF, 0, mk(4'd12, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 4'd0, 2'd3, 1, 0), "jal_tgt");
      // illegal opcode: two cycles, pulse in DECODE, back to FETCH
      add(0, 32'hFFFFFFFF, 0, F_ST, "ill_f");
      add(0, 32'hFFFFFFFF, 0, mk(4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 2'd0, 0, 1), "ill_d");
      // srai x1,x1,3: I-type uses funct7[5] for SRA
      add(0, 32'h4030D093, 0, F_ST, "srai_f");
      add(0, 32'h4030D093, 0, D_ST, "srai_d");
      add(0, 32'h4030D093, 0, mk(4'd7, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 4'd8, 2'd0, 0, 0), "srai_ex");
      add(0, 32'h4030D093, 0, W_ST, "srai_wb");
      // addi with imm bit 30 set: must stay ADD
      add(0, 32'h40000093, 0, F_ST, "addi30_f");
      add(0, 32'h40000093, 0, D_ST, "addi30_d");
      add(0, 32'h40000093, 0, EI_ADD, "addi30_ex");
      add(0, 32'h40000093, 0, W_ST, "addi30_wb");
      // sltu, xor, and (R-type)
      add(0, 32'h0020B033, 0, F_ST, "sltu_f");
      add(0, 32'h0020B033, 0, D_ST, "sltu_d");
      add(0, 32'h0020B033, 0, mk(4'd6, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 4'd9, 2'd0, 0, 0), "sltu_ex");
      add(0, 32'h0020B033, 0, W_ST, "sltu_wb");
      add(0, 32'h0020C033, 0, F_ST, "xor_f");
      add(0, 32'h0020C033, 0, D_ST, "xor_d");
      add(0, 32'h0020C033, 0, mk(4'd6, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 4'd4, 2'd0, 0, 0), "xor_ex");
      add(0, 32'h0020C033, 0, W_ST, "xor_wb");
      add(0, 32'h0020F033, 0, F_ST, "and_f");
      add(0, 32'h0020F033, 0, D_ST, "and_d");
      add(0, 32'h0020F033, 0, mk(4'd6, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 4'd2, 2'd0, 0, 0), "and_ex");
      add(0, 32'h0020F033, 0, W_ST, "and_wb");

      foreach (tbl[i]) check_row(tbl[i].rst, tbl[i].ins, tbl[i].z, tbl[i].exp, tbl[i].name);

      // Reset asserted mid-cycle while in MEMREAD: abandon the load at once
      check_row(0, 32'h0000A103, 0, F_ST, "lwr_f");
      check_row(0, 32'h0000A103, 0, D_ST, "lwr_d");
      check_row(0, 32'h0000A103, 0, mk(4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 4'd0, 2'd0, 0, 0), "lwr_adr");
      check_row(0, 32'h0000A103, 0, mk(4'd3, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 2'd0, 0, 0), "lwr_rd");
      #1 reset = 1'b1;
      #1;
      n_vec++;
      if (actual() !== R_ST) begin
         n_bad++;
         $display("FAIL midreset outputs: got %h want %h", actual(), R_ST);
      end
      n_vec++;
      if (instret !== 4'd0) begin
         n_bad++;
         $display("FAIL midreset instret: got %0d want 0", instret);
      end
      $display("vec midreset  st=%0d out=%h instret=%0d", state_dbg, actual(), instret);
      exp_cnt = 4'd0;

      // Sixteen retires wrap the 4-bit counter back to zero
      for (int k = 0; k < 16; k++) begin
         check_row(0, 32'h00A00093, 0, F_ST, "wrap_f");
         check_row(0, 32'h00A00093, 0, D_ST, "wrap_d");
         check_row(0, 32'h00A00093, 0, EI_ADD, "wrap_ex");
         if (k == 15) begin
            n_vec++;
            if (instret !== 4'd15) begin
               n_bad++;
               $display("FAIL wrap_pre: instret got %0d want 15", instret);
            end
         end
         check_row(0, 32'h00A00093, 0, W_ST, "wrap_wb");
      end
      check_row(0, 32'h00A00093, 0, F_ST, "wrap_end");
      n_vec++;
      if (instret !== 4'd0) begin
         n_bad++;
         $display("FAIL wrap_zero: instret got %0d want 0", instret);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
